// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for the shared 32-bit ALU.
// Grants one operation at a time, runs it through the ALU from registered
// operands, returns the registered result/status to the owner and keeps the
// architected NZCV flag register.
//
// Handshake rule (both request and response sides): a transfer happens in a
// cycle where valid and ready are both 1 at the rising clock edge. Valid may
// be withdrawn before ready without effect. Ready never depends on the value
// of the transferred payload.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic [WIDTH-1:0] req1_b_i,
    input  logic [1:0]       req0_op_i,
    input  logic [1:0]       req1_op_i,
    input  logic             req0_signed_i,
    input  logic             req1_signed_i,
    input  logic             req0_setflags_i,
    input  logic             req1_setflags_i,
    output logic [1:0]       rsp_valid_o,
    input  logic [1:0]       rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic [3:0]       rsp_status_o,
    output logic [3:0]       flags_o,
    output logic [WIDTH-1:0] alu_data1_o,
    output logic [WIDTH-1:0] alu_data2_o,
    output logic [1:0]       alu_opcode_o,
    output logic             alu_signed_o,
    output logic             alu_set_status_o,
    input  logic [WIDTH-1:0] alu_data_i,
    input  logic [3:0]       alu_status_i,
    output logic [1:0]       dbg_state_o
);

    localparam logic [1:0] OP_CMP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic             prio_q;
    logic             owner_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic             signed_q;
    logic             setflags_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic [3:0]       rsp_status_q;
    logic [3:0]       flags_q;

    logic             winner;
    logic             grant;
    logic             set_status;
    logic             rsp_fire;

    // Pick the winner: a lone requester wins, a tie goes to prio.
    always_comb begin
        winner = prio_q;
        if (req_valid_i == 2'b01) begin
            winner = 1'b0;
        end else if (req_valid_i == 2'b10) begin
            winner = 1'b1;
        end
    end

    assign grant      = (state_q == IDLE) && (req_valid_i != 2'b00);
    assign set_status = (state_q == EXEC) && (setflags_q || (op_q == OP_CMP));
    assign rsp_fire   = (state_q == RESP) && rsp_ready_i[owner_q];

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 2'b00;
        rsp_valid_o = 2'b00;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    req_ready_o = winner ? 2'b10 : 2'b01;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_o = owner_q ? 2'b10 : 2'b01;
                if (rsp_fire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture on grant, result and flag capture in EXEC.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q       <= 1'b0;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= 2'd0;
            signed_q     <= 1'b0;
            setflags_q   <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= 4'd0;
            flags_q      <= 4'd0;
        end else begin
            if (grant) begin
                owner_q <= winner;
                prio_q  <= ~winner;
                if (winner) begin
                    a_q        <= req1_a_i;
                    b_q        <= req1_b_i;
                    op_q       <= req1_op_i;
                    signed_q   <= req1_signed_i;
                    setflags_q <= req1_setflags_i;
                end else begin
                    a_q        <= req0_a_i;
                    b_q        <= req0_b_i;
                    op_q       <= req0_op_i;
                    signed_q   <= req0_signed_i;
                    setflags_q <= req0_setflags_i;
                end
            end
            if (state_q == EXEC) begin
                rsp_data_q   <= alu_data_i;
                rsp_status_q <= alu_status_i;
                if (set_status) begin
                    flags_q <= alu_status_i;
                end
            end
        end
    end

    assign rsp_data_o       = rsp_data_q;
    assign rsp_status_o     = rsp_status_q;
    assign flags_o          = flags_q;
    assign alu_data1_o      = a_q;
    assign alu_data2_o      = b_q;
    assign alu_opcode_o     = op_q;
    assign alu_signed_o     = signed_q;
    assign alu_set_status_o = set_status;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus randomized traffic for alu_arbiter,
// with a transaction-level reference model checked every cycle.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_ni;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_a, req1_a, req0_b, req1_b;
    logic [1:0]  req0_op, req1_op;
    logic        req0_signed, req1_signed, req0_setflags, req1_setflags;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_status;
    logic [3:0]  flags;
    logic [31:0] alu_data1, alu_data2;
    logic [1:0]  alu_opcode;
    logic        alu_signed, alu_set_status;
    logic [31:0] alu_data;
    logic [3:0]  alu_status;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit model_on = 1'b0;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req0_a_i(req0_a), .req1_a_i(req1_a),
        .req0_b_i(req0_b), .req1_b_i(req1_b),
        .req0_op_i(req0_op), .req1_op_i(req1_op),
        .req0_signed_i(req0_signed), .req1_signed_i(req1_signed),
        .req0_setflags_i(req0_setflags), .req1_setflags_i(req1_setflags),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_status_o(rsp_status), .flags_o(flags),
        .alu_data1_o(alu_data1), .alu_data2_o(alu_data2),
        .alu_opcode_o(alu_opcode), .alu_signed_o(alu_signed),
        .alu_set_status_o(alu_set_status),
        .alu_data_i(alu_data), .alu_status_i(alu_status),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ALU behaviour: returns {status[3:0], data[31:0]}; status is zero when not enabled.
    function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op, input logic sgn, input logic set);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        s = 33'd0; c = 1'b0; v = 1'b0;
        case (op)
            2'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            2'd1, 2'd2: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            default: r = a << b[4:0];
        endcase
        if (!set) return {4'd0, r};
        return {r[31], (r == 32'd0), (sgn ? 1'b0 : c), (sgn ? v : 1'b0), r};
    endfunction

    // Combinational ALU stub driven by the DUT's ALU port.
    always_comb {alu_status, alu_data} = alu_f(alu_data1, alu_data2, alu_opcode, alu_signed, alu_set_status);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    bit          m_busy = 1'b0;
    bit          m_prio = 1'b0;
    bit          m_owner = 1'b0;
    bit          m_set = 1'b0;
    int          m_gcyc = 0;
    logic [31:0] m_data = '0;
    logic [3:0]  m_status = '0;
    logic [3:0]  m_prev = '0;
    logic [3:0]  m_cur = '0;

    always @(negedge clk) begin
        if (model_on) begin
            if (!rst_ni) begin
                m_busy = 1'b0; m_prio = 1'b0; m_prev = 4'd0; m_cur = 4'd0;
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_data", rsp_data, 0);
                chk("rst_rsp_status", rsp_status, 0);
                chk("rst_flags", flags, 0);
                chk("rst_alu_set_status", alu_set_status, 0);
            end else begin
                logic [1:0]  e_ready, e_rv;
                logic        w;
                logic [35:0] res;
                w = (req_valid == 2'b11) ? m_prio : req_valid[1];
                e_ready = (!m_busy && req_valid != 2'b00) ? (w ? 2'b10 : 2'b01) : 2'b00;
                e_rv = (m_busy && cyc >= m_gcyc + 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
                chk("m_req_ready", req_ready, e_ready);
                chk("m_rsp_valid", rsp_valid, e_rv);
                if (e_rv != 2'b00) begin
                    chk("m_rsp_data", rsp_data, m_data);
                    chk("m_rsp_status", rsp_status, m_status);
                end
                chk("m_flags", flags, (m_busy && cyc < m_gcyc + 2) ? m_prev : m_cur);
                chk("m_alu_set_status", alu_set_status, (m_busy && cyc == m_gcyc + 1) ? m_set : 1'b0);
                if (e_rv != 2'b00 && rsp_ready[m_owner]) m_busy = 1'b0;
                if (e_ready != 2'b00) begin
                    m_busy = 1'b1; m_owner = w; m_prio = ~w; m_gcyc = cyc;
                    if (w) begin
                        m_set = req1_setflags || (req1_op == 2'd2);
                        res = alu_f(req1_a, req1_b, req1_op, req1_signed, m_set);
                    end else begin
                        m_set = req0_setflags || (req0_op == 2'd2);
                        res = alu_f(req0_a, req0_b, req0_op, req0_signed, m_set);
                    end
                    m_data = res[31:0]; m_status = res[35:32];
                    m_prev = m_cur;
                    if (m_set) m_cur = res[35:32];
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input logic sgn, input logic sf);
        if (i == 0) begin
            req0_a = a; req0_b = b; req0_op = op; req0_signed = sgn; req0_setflags = sf;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_signed = sgn; req1_setflags = sf;
        end
    endtask

    task automatic do_reset();
        step(); rst_ni = 1'b0; req_valid = 2'b00;
        step(); step(); rst_ni = 1'b1;
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'h7fffffff;
            3: return 32'h80000000;
            4: return 32'hffffffff;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [1:0] g;
        int n;
        rst_ni = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
        set_req(0, 0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0, 0);
        #2 rst_ni = 1'b0;
        model_on = 1'b1;
        @(negedge clk);
        chk("reset_dbg_state", dbg_state, 0);
        step(); step(); rst_ni = 1'b1;

        // Single ADD from requester 0, no flag update.
        step(); set_req(0, 5, 7, 2'd0, 1'b0, 1'b0); req_valid = 2'b01;
        @(negedge clk); chk("add_ready", req_ready, 2'b01);
        step(); req_valid = 2'b00;
        @(negedge clk); chk("add_no_early_rsp", rsp_valid, 2'b00);
        @(negedge clk);
        chk("add_rsp_valid", rsp_valid, 2'b01);
        chk("add_rsp_data", rsp_data, 12);
        chk("add_rsp_status", rsp_status, 0);
        chk("add_flags", flags, 0);

        // Simultaneous requests after reset: requester 0 first, carry-out flags.
        do_reset();
        set_req(0, 32'hffffffff, 1, 2'd0, 1'b0, 1'b1);
        set_req(1, 1, 1, 2'd0, 1'b0, 1'b0);
        req_valid = 2'b11;
        @(negedge clk); chk("tie_ready", req_ready, 2'b01);
        step(); req_valid = 2'b10;
        @(negedge clk);
        @(negedge clk);
        chk("carry_rsp_data", rsp_data, 0);
        chk("carry_rsp_status", rsp_status, 4'b0110);
        chk("carry_flags", flags, 4'b0110);
        @(negedge clk); chk("tie_second_grant", req_ready, 2'b10);
        step(); req_valid = 2'b00;
        repeat (4) step();

        // Both continuously valid: alternating grants.
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            @(negedge clk);
            while (req_ready == 2'b00 && n < 10) begin
                @(negedge clk); n++;
            end
            g = (k % 2 == 1) ? 2'b10 : 2'b01;
            chk("rr_grant_order", req_ready, g);
            @(negedge clk);
            @(negedge clk);
            chk("rr_rsp_after_2", rsp_valid, g);
        end
        step(); req_valid = 2'b00;
        repeat (3) step();

        // CMP always updates flags.
        set_req(0, 3, 3, 2'd2, 1'b1, 1'b0); req_valid = 2'b01;
        @(negedge clk); chk("cmp_ready", req_ready, 2'b01);
        step(); req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("cmp_flags", flags, 4'b0100);
        chk("cmp_rsp_data", rsp_data, 0);
        repeat (2) step();

        // Stalled response blocks the other requester.
        rsp_ready = 2'b10;
        set_req(0, 9, 1, 2'd0, 1'b0, 1'b0); req_valid = 2'b01;
        @(negedge clk);
        step(); set_req(1, 2, 3, 2'd0, 1'b0, 1'b0); req_valid = 2'b10;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_rsp_valid", rsp_valid, 2'b01);
            chk("stall_rsp_data", rsp_data, 10);
            chk("stall_req_ready", req_ready, 2'b00);
        end
        step(); rsp_ready = 2'b11;
        @(negedge clk); chk("stall_release_valid", rsp_valid, 2'b01);
        @(negedge clk); chk("stall_next_grant", req_ready, 2'b10);
        step(); req_valid = 2'b00;
        repeat (4) step();

        // Reset during EXEC of a setflags SUB.
        set_req(0, 1, 2, 2'd1, 1'b0, 1'b1); req_valid = 2'b01;
        @(negedge clk); chk("rst_exec_ready", req_ready, 2'b01);
        step(); rst_ni = 1'b0; req_valid = 2'b00;
        @(negedge clk); chk("rst_exec_flags", flags, 0);
        step(); rst_ni = 1'b1;
        @(negedge clk);
        chk("rst_exec_no_rsp", rsp_valid, 2'b00);
        chk("rst_exec_flags_after", flags, 0);
        chk("rst_exec_idle", dbg_state, 0);
        step(); set_req(1, 4, 4, 2'd0, 1'b0, 1'b1); req_valid = 2'b10;
        @(negedge clk); chk("rst_exec_new_grant", req_ready, 2'b10);
        step(); req_valid = 2'b00;
        repeat (4) step();

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            step();
            if ($urandom_range(0, 299) == 0) begin
                rst_ni = 1'b0;
                req_valid = 2'b00;
            end else begin
                rst_ni = 1'b1;
                req_valid = 2'($urandom_range(0, 3));
            end
            rsp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            set_req(0, rand_val(), rand_val(), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            set_req(1, rand_val(), rand_val(), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        step(); rst_ni = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
